// File: rtl/decode_stage.sv
// RV64I decode stage: combinational decode of the fetched instruction into a
// control bundle, buffered in a DEPTH-entry FIFO towards execute.
// Optional feature macro: DECODE_ILLEGAL_EN (flag illegal encodings on illegal_o).
// Without it, illegal_o is tied low and unknown encodings decode as NOP bundles.

package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LD   = 4'd4,
        LSU_LBU  = 4'd5,
        LSU_LHU  = 4'd6,
        LSU_LWU  = 4'd7,
        LSU_SB   = 4'd8,
        LSU_SH   = 4'd9,
        LSU_SW   = 4'd10,
        LSU_SD   = 4'd11
    } lsu_op_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

endpackage

module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_addr_o,
    output alu_op_t         alu_op_o,
    output lsu_op_t         lsu_op_o,
    output logic            reg_write_o,
    output logic            alu_src_o,
    output logic            mem_write_o,
    output logic            mem_to_reg_o,
    output logic            alu_a_pc_o,
    output logic            word_op_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic [2:0]      funct3_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        alu_op_t         alu_op;
        lsu_op_t         lsu_op;
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_a_pc;
        logic            word_op;
        logic            branch;
        logic            jump;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    // Instruction fields
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [5:0]      w_funct6;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_alt;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    bundle_t w_raw;
    bundle_t w_dec;
    bundle_t w_head;
    logic    w_bad;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    bundle_t       r_mem [DEPTH];
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_opcode = instr_i[6:0];
    assign w_rd     = instr_i[11:7];
    assign w_funct3 = instr_i[14:12];
    assign w_rs1    = instr_i[19:15];
    assign w_rs2    = instr_i[24:20];
    assign w_funct7 = instr_i[31:25];
    assign w_funct6 = instr_i[31:26];
    assign w_alt    = instr_i[30];

    assign w_imm_i = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_b = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};

    // Opcode/funct decode into a raw bundle plus an encoding-invalid flag
    always_comb begin
        w_raw        = '0;
        w_bad        = 1'b0;
        w_raw.funct3 = w_funct3;
        case (w_opcode)
            OPC_LUI: begin
                w_raw.rd        = w_rd;
                w_raw.reg_write = 1'b1;
                w_raw.alu_src   = 1'b1;
                w_raw.imm       = w_imm_u;
            end
            OPC_AUIPC: begin
                w_raw.rd        = w_rd;
                w_raw.reg_write = 1'b1;
                w_raw.alu_src   = 1'b1;
                w_raw.alu_a_pc  = 1'b1;
                w_raw.imm       = w_imm_u;
            end
            OPC_JAL: begin
                w_raw.rd        = w_rd;
                w_raw.reg_write = 1'b1;
                w_raw.alu_src   = 1'b1;
                w_raw.alu_a_pc  = 1'b1;
                w_raw.jump      = 1'b1;
                w_raw.imm       = w_imm_j;
            end
            OPC_JALR: begin
                w_raw.rd        = w_rd;
                w_raw.rs1       = w_rs1;
                w_raw.reg_write = 1'b1;
                w_raw.alu_src   = 1'b1;
                w_raw.jump      = 1'b1;
                w_raw.imm       = w_imm_i;
            end
            OPC_BRANCH: begin
                w_raw.rs1    = w_rs1;
                w_raw.rs2    = w_rs2;
                w_raw.branch = 1'b1;
                w_raw.alu_op = ALU_SUB;
                w_raw.imm    = w_imm_b;
            end
            OPC_LOAD: begin
                w_raw.rd         = w_rd;
                w_raw.rs1        = w_rs1;
                w_raw.reg_write  = 1'b1;
                w_raw.alu_src    = 1'b1;
                w_raw.mem_to_reg = 1'b1;
                w_raw.imm        = w_imm_i;
                case (w_funct3)
                    3'b000:  w_raw.lsu_op = LSU_LB;
                    3'b001:  w_raw.lsu_op = LSU_LH;
                    3'b010:  w_raw.lsu_op = LSU_LW;
                    3'b011:  w_raw.lsu_op = LSU_LD;
                    3'b100:  w_raw.lsu_op = LSU_LBU;
                    3'b101:  w_raw.lsu_op = LSU_LHU;
                    3'b110:  w_raw.lsu_op = LSU_LWU;
                    default: w_bad        = 1'b1;
                endcase
            end
            OPC_STORE: begin
                w_raw.rs1       = w_rs1;
                w_raw.rs2       = w_rs2;
                w_raw.mem_write = 1'b1;
                w_raw.alu_src   = 1'b1;
                w_raw.imm       = w_imm_s;
                case (w_funct3)
                    3'b000:  w_raw.lsu_op = LSU_SB;
                    3'b001:  w_raw.lsu_op = LSU_SH;
                    3'b010:  w_raw.lsu_op = LSU_SW;
                    3'b011:  w_raw.lsu_op = LSU_SD;
                    default: w_bad        = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                w_raw.rd        = w_rd;
                w_raw.rs1       = w_rs1;
                w_raw.reg_write = 1'b1;
                w_raw.alu_src   = 1'b1;
                w_raw.imm       = w_imm_i;
                case (w_funct3)
                    3'b000: w_raw.alu_op = ALU_ADD;
                    3'b010: w_raw.alu_op = ALU_SLT;
                    3'b011: w_raw.alu_op = ALU_SLTU;
                    3'b100: w_raw.alu_op = ALU_XOR;
                    3'b110: w_raw.alu_op = ALU_OR;
                    3'b111: w_raw.alu_op = ALU_AND;
                    3'b001: begin
                        // RV64 shamt is 6 bits, so only funct6 is checked
                        w_raw.alu_op = ALU_SLL;
                        if (w_funct6 != 6'b000000) w_bad = 1'b1;
                    end
                    default: begin
                        w_raw.alu_op = w_alt ? ALU_SRA : ALU_SRL;
                        if (w_funct6 != 6'b000000 && w_funct6 != 6'b010000) w_bad = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                w_raw.rd        = w_rd;
                w_raw.rs1       = w_rs1;
                w_raw.rs2       = w_rs2;
                w_raw.reg_write = 1'b1;
                case (w_funct3)
                    3'b000:  w_raw.alu_op = w_alt ? ALU_SUB : ALU_ADD;
                    3'b001:  w_raw.alu_op = ALU_SLL;
                    3'b010:  w_raw.alu_op = ALU_SLT;
                    3'b011:  w_raw.alu_op = ALU_SLTU;
                    3'b100:  w_raw.alu_op = ALU_XOR;
                    3'b101:  w_raw.alu_op = w_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  w_raw.alu_op = ALU_OR;
                    default: w_raw.alu_op = ALU_AND;
                endcase
                // funct7 0x20 only encodes SUB and SRA
                if (!(w_funct7 == 7'h00 ||
                      (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))))
                    w_bad = 1'b1;
            end
            OPC_OP_IMM_32: begin
                w_raw.rd        = w_rd;
                w_raw.rs1       = w_rs1;
                w_raw.reg_write = 1'b1;
                w_raw.alu_src   = 1'b1;
                w_raw.word_op   = 1'b1;
                w_raw.imm       = w_imm_i;
                case (w_funct3)
                    3'b000: w_raw.alu_op = ALU_ADD;
                    3'b001: begin
                        w_raw.alu_op = ALU_SLL;
                        if (w_funct7 != 7'h00) w_bad = 1'b1;
                    end
                    3'b101: begin
                        w_raw.alu_op = w_alt ? ALU_SRA : ALU_SRL;
                        if (w_funct7 != 7'h00 && w_funct7 != 7'h20) w_bad = 1'b1;
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                w_raw.rd        = w_rd;
                w_raw.rs1       = w_rs1;
                w_raw.rs2       = w_rs2;
                w_raw.reg_write = 1'b1;
                w_raw.word_op   = 1'b1;
                case (w_funct3)
                    3'b000: begin
                        w_raw.alu_op = w_alt ? ALU_SUB : ALU_ADD;
                        if (w_funct7 != 7'h00 && w_funct7 != 7'h20) w_bad = 1'b1;
                    end
                    3'b001: begin
                        w_raw.alu_op = ALU_SLL;
                        if (w_funct7 != 7'h00) w_bad = 1'b1;
                    end
                    3'b101: begin
                        w_raw.alu_op = w_alt ? ALU_SRA : ALU_SRL;
                        if (w_funct7 != 7'h00 && w_funct7 != 7'h20) w_bad = 1'b1;
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            // Unknown opcodes, including any with instr[1:0] != 2'b11
            default: w_bad = 1'b1;
        endcase
    end

    // Invalid encodings become NOP bundles, so they never write rd or memory
    always_comb begin
        w_dec = w_raw;
        if (w_bad) w_dec = '0;
        w_dec.pc = pc_i;
`ifdef DECODE_ILLEGAL_EN
        w_dec.illegal = w_bad;
`else
        w_dec.illegal = 1'b0;
`endif
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = fetch_valid_i & ~w_full;
    assign w_pop   = ~w_empty & ex_ready_i;

    // FIFO pointers; flush empties the buffer and wins over push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Bundle storage written at the tail on an accepted push
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i && !rst_i) r_mem[r_wr_ptr[AW-1:0]] <= w_dec;
    end

    // Head bundle, presented as a NOP while the FIFO is empty
    always_comb begin
        w_head = '0;
        if (!w_empty) w_head = r_mem[r_rd_ptr[AW-1:0]];
    end

    assign fetch_ready_o = ~w_full;
    assign ex_valid_o    = ~w_empty;
    assign pc_o          = w_head.pc;
    assign rs1_addr_o    = w_head.rs1;
    assign rs2_addr_o    = w_head.rs2;
    assign rd_addr_o     = w_head.rd;
    assign alu_op_o      = w_head.alu_op;
    assign lsu_op_o      = w_head.lsu_op;
    assign reg_write_o   = w_head.reg_write;
    assign alu_src_o     = w_head.alu_src;
    assign mem_write_o   = w_head.mem_write;
    assign mem_to_reg_o  = w_head.mem_to_reg;
    assign alu_a_pc_o    = w_head.alu_a_pc;
    assign word_op_o     = w_head.word_op;
    assign branch_o      = w_head.branch;
    assign jump_o        = w_head.jump;
    assign funct3_o      = w_head.funct3;
    assign imm_o         = w_head.imm;
    assign illegal_o     = w_head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed spec vectors plus randomized traffic
// checked against a queue-based reference model.

module tb_decode_stage;
    import riscv_pkg::*;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 2;

    logic            clk;
    logic            rst_i;
    logic            fetch_valid_i;
    logic            fetch_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            flush_i;
    logic            ex_valid_o;
    logic            ex_ready_i;
    logic [XLEN-1:0] pc_o;
    logic [4:0]      rs1_addr_o;
    logic [4:0]      rs2_addr_o;
    logic [4:0]      rd_addr_o;
    alu_op_t         alu_op_o;
    lsu_op_t         lsu_op_o;
    logic            reg_write_o;
    logic            alu_src_o;
    logic            mem_write_o;
    logic            mem_to_reg_o;
    logic            alu_a_pc_o;
    logic            word_op_o;
    logic            branch_o;
    logic            jump_o;
    logic [2:0]      funct3_o;
    logic [XLEN-1:0] imm_o;
    logic            illegal_o;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .pc_o          (pc_o),
        .rs1_addr_o    (rs1_addr_o),
        .rs2_addr_o    (rs2_addr_o),
        .rd_addr_o     (rd_addr_o),
        .alu_op_o      (alu_op_o),
        .lsu_op_o      (lsu_op_o),
        .reg_write_o   (reg_write_o),
        .alu_src_o     (alu_src_o),
        .mem_write_o   (mem_write_o),
        .mem_to_reg_o  (mem_to_reg_o),
        .alu_a_pc_o    (alu_a_pc_o),
        .word_op_o     (word_op_o),
        .branch_o      (branch_o),
        .jump_o        (jump_o),
        .funct3_o      (funct3_o),
        .imm_o         (imm_o),
        .illegal_o     (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu, lsu;
        logic        rw, asrc, mw, m2r, apc, word, br, jmp;
        logic [2:0]  f3;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    localparam logic [3:0] ALU_BY_F3 [8] = '{4'(ALU_ADD), 4'(ALU_SLL), 4'(ALU_SLT), 4'(ALU_SLTU),
                                             4'(ALU_XOR), 4'(ALU_SRL), 4'(ALU_OR),  4'(ALU_AND)};
    localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                        7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t mq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode: classify by opcode, derive controls from instruction meaning
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        bit          ok, w_rd, u_rs1, u_rs2;
        e     = '{default: 0};
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = 64'($signed(ins[31:20]));
        imm_s = 64'($signed({ins[31:25], ins[11:7]}));
        imm_b = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        imm_u = 64'($signed({ins[31:12], 12'h000}));
        imm_j = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        ok = 1; w_rd = 0; u_rs1 = 0; u_rs2 = 0;
        case (ins[6:0])
            7'h37: begin w_rd = 1; e.asrc = 1; e.imm = imm_u; end
            7'h17: begin w_rd = 1; e.asrc = 1; e.apc = 1; e.imm = imm_u; end
            7'h6F: begin w_rd = 1; e.asrc = 1; e.apc = 1; e.jmp = 1; e.imm = imm_j; end
            7'h67: begin w_rd = 1; u_rs1 = 1; e.asrc = 1; e.jmp = 1; e.imm = imm_i; end
            7'h63: begin u_rs1 = 1; u_rs2 = 1; e.br = 1; e.alu = 4'(ALU_SUB); e.imm = imm_b; end
            7'h03: begin
                w_rd = 1; u_rs1 = 1; e.asrc = 1; e.m2r = 1; e.imm = imm_i;
                ok = (f3 != 3'd7);
                e.lsu = 4'(LSU_LB) + 4'(f3);
            end
            7'h23: begin
                u_rs1 = 1; u_rs2 = 1; e.asrc = 1; e.mw = 1; e.imm = imm_s;
                ok = (f3 < 3'd4);
                e.lsu = 4'(LSU_SB) + 4'(f3);
            end
            7'h13: begin
                w_rd = 1; u_rs1 = 1; e.asrc = 1; e.imm = imm_i;
                e.alu = ALU_BY_F3[f3];
                if (f3 == 3'd5 && ins[31:26] == 6'h10) e.alu = 4'(ALU_SRA);
                if (f3 == 3'd1) ok = (ins[31:26] == 6'h00);
                if (f3 == 3'd5) ok = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h10);
            end
            7'h33: begin
                w_rd = 1; u_rs1 = 1; u_rs2 = 1;
                e.alu = ALU_BY_F3[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'(ALU_SUB);
                if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'(ALU_SRA);
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'h1B: begin
                w_rd = 1; u_rs1 = 1; e.asrc = 1; e.word = 1; e.imm = imm_i;
                e.alu = ALU_BY_F3[f3];
                if (f3 == 3'd5 && f7 == 7'h20) e.alu = 4'(ALU_SRA);
                ok = (f3 == 3'd0) || (f3 == 3'd1 && f7 == 7'h00) ||
                     (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20));
            end
            7'h3B: begin
                w_rd = 1; u_rs1 = 1; u_rs2 = 1; e.word = 1;
                e.alu = ALU_BY_F3[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'(ALU_SUB);
                if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'(ALU_SRA);
                ok = (f3 inside {3'd0, 3'd1, 3'd5}) &&
                     ((f7 == 7'h00) || (f7 == 7'h20 && f3 != 3'd1));
            end
            default: ok = 0;
        endcase
        e.rw  = w_rd;
        e.rd  = w_rd  ? ins[11:7]  : 5'd0;
        e.rs1 = (u_rs1 && ins[6:0] != 7'h37) ? ins[19:15] : 5'd0;
        e.rs2 = u_rs2 ? ins[24:20] : 5'd0;
        e.f3  = f3;
        if (!ok) e = '{default: 0};
        e.pc = pc;
`ifdef DECODE_ILLEGAL_EN
        e.ill = !ok;
`endif
        return e;
    endfunction

    // Compare every DUT output against the model head (or NOP when empty)
    task automatic compare_all();
        exp_t e;
        e = '{default: 0};
        if (mq.size() != 0) e = mq[0];
        check("fetch_ready", 64'(fetch_ready_o), 64'(mq.size() < DEPTH));
        check("ex_valid",    64'(ex_valid_o),    64'(mq.size() != 0));
        check("pc",          pc_o,               e.pc);
        check("rs1",         64'(rs1_addr_o),    64'(e.rs1));
        check("rs2",         64'(rs2_addr_o),    64'(e.rs2));
        check("rd",          64'(rd_addr_o),     64'(e.rd));
        check("alu_op",      64'(alu_op_o),      64'(e.alu));
        check("lsu_op",      64'(lsu_op_o),      64'(e.lsu));
        check("reg_write",   64'(reg_write_o),   64'(e.rw));
        check("alu_src",     64'(alu_src_o),     64'(e.asrc));
        check("mem_write",   64'(mem_write_o),   64'(e.mw));
        check("mem_to_reg",  64'(mem_to_reg_o),  64'(e.m2r));
        check("alu_a_pc",    64'(alu_a_pc_o),    64'(e.apc));
        check("word_op",     64'(word_op_o),     64'(e.word));
        check("branch",      64'(branch_o),      64'(e.br));
        check("jump",        64'(jump_o),        64'(e.jmp));
        check("funct3",      64'(funct3_o),      64'(e.f3));
        check("imm",         imm_o,              e.imm);
        check("illegal",     64'(illegal_o),     64'(e.ill));
    endtask

    // One clock: drive at negedge, advance the model, compare at the next negedge
    task automatic cycle(input logic fv, input logic [31:0] ins, input logic [63:0] pc,
                         input logic er, input logic fl);
        bit do_push, do_pop;
        fetch_valid_i = fv;
        instr_i       = ins;
        pc_i          = pc;
        ex_ready_i    = er;
        flush_i       = fl;
        do_push = fv && (mq.size() < DEPTH);
        do_pop  = er && (mq.size() != 0);
        if (fl) mq.delete();
        else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(ref_decode(ins, pc));
        end
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int unsigned r;
        ins = $urandom;
        if ($urandom_range(0, 9) != 0) ins[6:0] = OPS[$urandom_range(0, 10)];
        r = $urandom_range(0, 9);
        if (r < 4)      ins[31:25] = 7'h00;
        else if (r < 7) ins[31:25] = 7'h20;
        return ins;
    endfunction

    initial begin
        rst_i = 1'b1; fetch_valid_i = 1'b0; instr_i = '0; pc_i = '0;
        ex_ready_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        compare_all();
        check("rst_ready", 64'(fetch_ready_o), 64'd1);
        check("rst_valid", 64'(ex_valid_o), 64'd0);
        check("rst_alu",   64'(alu_op_o), 64'(ALU_ADD));
        check("rst_lsu",   64'(lsu_op_o), 64'(LSU_NONE));

        // addi x1,x0,-1
        cycle(1'b1, 32'hFFF00093, 64'h1000, 1'b0, 1'b0);
        check("addi_valid", 64'(ex_valid_o), 64'd1);
        check("addi_rd",    64'(rd_addr_o), 64'd1);
        check("addi_alu",   64'(alu_op_o), 64'(ALU_ADD));
        check("addi_src",   64'(alu_src_o), 64'd1);
        check("addi_imm",   imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // sd x2,8(x1)
        cycle(1'b1, 32'h0020B423, 64'h1004, 1'b0, 1'b0);
        check("sd_imm", imm_o, 64'd8);
        check("sd_mw",  64'(mem_write_o), 64'd1);
        check("sd_lsu", 64'(lsu_op_o), 64'(LSU_SD));
        check("sd_rw",  64'(reg_write_o), 64'd0);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // beq x0,x0,-4
        cycle(1'b1, 32'hFE000EE3, 64'h1008, 1'b0, 1'b0);
        check("beq_br",  64'(branch_o), 64'd1);
        check("beq_f3",  64'(funct3_o), 64'd0);
        check("beq_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Back-pressure: third instruction held while full, then in-order drain
        cycle(1'b1, 32'h00100093, 64'h2000, 1'b0, 1'b0);
        check("bp_ready1", 64'(fetch_ready_o), 64'd1);
        cycle(1'b1, 32'h00200113, 64'h2004, 1'b0, 1'b0);
        check("bp_ready2", 64'(fetch_ready_o), 64'd0);
        cycle(1'b1, 32'h00300193, 64'h2008, 1'b0, 1'b0);
        check("bp_hold_pc", pc_o, 64'h2000);
        cycle(1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0);
        check("bp_pop1_pc", pc_o, 64'h2004);
        cycle(1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0);
        check("bp_pop2_pc", pc_o, 64'h2008);
        check("bp_pop2_rd", 64'(rd_addr_o), 64'd3);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        check("bp_empty", 64'(ex_valid_o), 64'd0);

        // Flush with two buffered and a valid input
        cycle(1'b1, 32'h00100093, 64'h3000, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 64'h3004, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300193, 64'h3008, 1'b1, 1'b1);
        check("fl_valid", 64'(ex_valid_o), 64'd0);
        check("fl_ready", 64'(fetch_ready_o), 64'd1);
        // Flush with one buffered and an acceptable push in the same cycle
        cycle(1'b1, 32'h00100093, 64'h3100, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 64'h3104, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        check("fl_nobundle", 64'(ex_valid_o), 64'd0);

        // All-zero instruction
        cycle(1'b1, 32'h00000000, 64'h4000, 1'b0, 1'b0);
`ifdef DECODE_ILLEGAL_EN
        check("zero_ill", 64'(illegal_o), 64'd1);
`else
        check("zero_ill", 64'(illegal_o), 64'd0);
        check("zero_imm", imm_o, 64'd0);
`endif
        check("zero_rw",  64'(reg_write_o), 64'd0);
        check("zero_alu", 64'(alu_op_o), 64'(ALU_ADD));
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), {$urandom, $urandom},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
